// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller, datapath and ALU.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALUOp and instruction function fields to an ALU code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [3:0] alu_control
);

    // Funct decode; op[5] separates R-type from I-type so addi never subtracts.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/execute and drives datapath controls.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    output logic       o_PCWrite,
    output logic       o_AdrSrc,
    output logic       o_MemWrite,
    output logic       o_IRWrite,
    output logic       o_RegWrite,
    output logic [1:0] o_ResultSrc,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [1:0] o_ImmSrc,
    output logic [3:0] o_ALUControl
);

    state_t     state;
    state_t     state_next;
    state_t     dec_state;
    logic [1:0] alu_op;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= RESET_STATE;
        else         state <= state_next;
    end

    // Next-state sequencing from current state and opcode.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (i_op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_IALU:      state_next = S_EXECUTEI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (i_op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = S_MEMWB;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_JAL:      state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
    end

    // While reset is held the outputs show FETCH so nothing partial is written.
    assign dec_state = i_reset ? S_FETCH : state;

    // Per-state control outputs; every enable defaults low.
    always_comb begin
        o_PCWrite   = 1'b0;
        o_AdrSrc    = ADR_PC;
        o_MemWrite  = 1'b0;
        o_IRWrite   = 1'b0;
        o_RegWrite  = 1'b0;
        o_ResultSrc = RES_ALUOUT;
        o_ALUSrcA   = SRCA_PC;
        o_ALUSrcB   = SRCB_RS2;
        alu_op      = ALUOP_ADD;
        case (dec_state)
            S_FETCH: begin
                o_IRWrite   = 1'b1;
                o_PCWrite   = 1'b1;
                o_ALUSrcB   = SRCB_FOUR;
                o_ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                o_ALUSrcA = SRCA_RS1;
                o_ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: o_AdrSrc = ADR_ALUOUT;
            S_MEMWB: begin
                o_ResultSrc = RES_DATA;
                o_RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                o_AdrSrc   = ADR_ALUOUT;
                o_MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                o_ALUSrcA = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                o_ALUSrcA = SRCA_RS1;
                o_ALUSrcB = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: o_RegWrite = 1'b1;
            S_JAL: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_FOUR;
                o_PCWrite = 1'b1;
            end
            S_BEQ: begin
                o_ALUSrcA = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                o_PCWrite = i_zero;
            end
            default: ;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        o_ImmSrc = IMM_I;
        case (i_op)
            OP_SW:   o_ImmSrc = IMM_S;
            OP_BEQ:  o_ImmSrc = IMM_B;
            OP_JAL:  o_ImmSrc = IMM_J;
            default: o_ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (i_funct3),
        .op_b5       (i_op[5]),
        .funct7b5    (i_funct7b5),
        .alu_control (o_ALUControl)
    );

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequential control unit for the multicycle RV32I datapath.
- Decodes the latched instruction fields and sequences FETCH→DECODE→execute states.
- Drives the datapath mux selects, the write enables and the 4-bit ALU operation code into the ALU.
- Consumes the ALU zero flag to resolve beq.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset.

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_op  in  7  instr[6:0] from instruction register
- i_funct3  in  3  instr[14:12]
- i_funct7b5  in  1  instr[30]
- i_zero  in  1  ALU zero flag, meaning result==0
- o_PCWrite  out  1  PC register enable
- o_AdrSrc  out  1  memory address select; 0=PC, 1=ALUOut
- o_MemWrite  out  1  data memory write enable
- o_IRWrite  out  1  instruction register and OldPC enable
- o_RegWrite  out  1  register file write enable
- o_ResultSrc  out  2  result select; 00=ALUOut, 01=Data, 10=ALUResult
- o_ALUSrcA  out  2  ALU A select; 00=PC, 01=OldPC, 10=rs1 reg
- o_ALUSrcB  out  2  ALU B select; 00=rs2 reg, 01=ImmExt, 10=const 4
- o_ImmSrc  out  2  immediate format; 00=I, 01=S, 10=B, 11=J
- o_ALUControl  out  4  ALU operation code

Behaviour:
- ALU codes: ADD=0000, SUB=0001, AND=0010, OR=0011, SLT=0101.
- Opcodes handled:
  - lw=0000011, sw=0100011, R=0110011, I-ALU=0010011, beq=1100011, jal=1101111.
- State register: 11 states (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, ALUWB, EXECUTEI, JAL, BEQ). All other outputs are decoded from the current state plus instruction fields.
- Reset: when i_reset=1 at a clock edge, state←FETCH, including mid-instruction, with no partial writes completed.
- Outputs while i_reset is asserted follow the FETCH decode. Each enable is 0 in every state where it is not listed.
- Transitions:
  - FETCH→DECODE.
  - DECODE: lw/sw→MEMADR, R→EXECUTER, I-ALU→EXECUTEI, jal→JAL, beq→BEQ, any other opcode→FETCH (NOP; no writes).
  - MEMADR: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER→ALUWB, EXECUTEI→ALUWB, JAL→ALUWB.
  - ALUWB→FETCH.
  - BEQ→FETCH.
- Per-state outputs (ALUOp is internal: 00=add, 01=sub, 10=funct-decoded):
  - FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1.
  - DECODE: SrcA=01, SrcB=01, ALUOp=00 (branch target precompute).
  - MEMADR: SrcA=10, SrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: SrcA=10, SrcB=00, ALUOp=10.
  - EXECUTEI: SrcA=10, SrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, PCWrite=i_zero (combinational, same cycle).
- ImmSrc is decoded from i_op in every state:
  - lw/I-ALU=00, sw=01, beq=10, jal=11, other=00.
- ALU decode:
  - ALUOp 00→ADD; 01→SUB.
  - ALUOp 10, funct3=000: SUB iff i_op[5]&i_funct7b5, else ADD. So addi is never SUB regardless of imm[10].
  - ALUOp 10, funct3=010→SLT; 110→OR; 111→AND; any other funct3→ADD.
- Latency in cycles: lw 5, sw 4, R/I 4, jal 4, beq 3.
- Inputs are sampled only through combinational decode. No input is registered except via state.

Decomposition:
- Package riscv_ctrl_pkg holds: state localparams, opcode constants, ALU code constants, ALUOp codes, and mux-select encodings, shared with the datapath and the ALU.
- One combinational sub-module, alu_decoder (ALUOp, funct3, op[5], funct7b5 → ALUControl).
- The FSM and the ImmSrc decode stay in the top module.

Test Plan:
- Reset: hold i_reset for 2 cycles mid-EXECUTER → next state FETCH; PCWrite=1, IRWrite=1, ALUControl=0000.
- lw (op=0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 only in cycle 5 with ResultSrc=01; ImmSrc=00.
- sw (op=0100011): MemWrite=1 only in cycle 4, AdrSrc=1; RegWrite never 1; ImmSrc=01.
- R-type sub (funct3=000, f7b5=1) → ALUControl=0001 in EXECUTER. addi with f7b5=1 → 0000. funct3=111 → 0010; 110 → 0011; 010 → 0101.
- beq with i_zero=1 in BEQ → PCWrite=1, ALUControl=0001. With i_zero=0 → PCWrite=0. Both return to FETCH after 3 cycles.
- jal (op=1101111): PCWrite=1 in JAL, then RegWrite=1 in ALUWB; ImmSrc=11. Illegal op 1111111 → DECODE→FETCH with no write enables.
